// File: rtl/divider_32.sv
// Multi-cycle RV32M divider: restoring division, one quotient bit per clock.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow finish straight from IDLE.
module divider_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        divzero
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_op;
    logic        r_a_neg, r_b_neg, r_bzero;
    logic [31:0] r_rem, r_quo, r_bmag;
    logic [4:0]  r_cnt;
    logic [31:0] r_result;
    logic        r_divzero;

    logic        w_signed_in, w_a_neg, w_b_neg, w_fast;
    logic [31:0] w_a_mag, w_b_mag;
    logic [32:0] w_shift, w_trial;
    logic        w_q_neg, w_r_neg;
    logic [31:0] w_quo_s, w_rem_s, w_fix_res;

    // op[0] == 0 selects the signed variants (DIV, REM)
    assign w_signed_in = ~op[0];
    assign w_a_neg     = w_signed_in & a[31];
    assign w_b_neg     = w_signed_in & b[31];
    assign w_a_mag     = w_a_neg ? (32'd0 - a) : a;
    assign w_b_mag     = w_b_neg ? (32'd0 - b) : b;

`ifdef DIV_FAST_SPECIAL_EN
    logic        w_bz_in, w_ovf_in;
    logic [31:0] w_fast_res;
    assign w_bz_in    = (b == 32'd0);
    assign w_ovf_in   = w_signed_in & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
    assign w_fast     = w_bz_in | w_ovf_in;
    assign w_fast_res = w_bz_in ? (op[1] ? a : 32'hFFFF_FFFF)
                                : (op[1] ? 32'd0 : 32'h8000_0000);
`else
    assign w_fast = 1'b0;
`endif

    // Remainder after restore is always below |b|, so only the trial needs bit 32
    assign w_shift = {r_rem, r_quo[31]};
    assign w_trial = w_shift - {1'b0, r_bmag};

    assign w_q_neg   = ~r_op[0] & (r_a_neg ^ r_b_neg) & ~r_bzero;
    assign w_r_neg   = ~r_op[0] & r_a_neg;
    assign w_quo_s   = w_q_neg ? (32'd0 - r_quo) : r_quo;
    assign w_rem_s   = w_r_neg ? (32'd0 - r_rem) : r_rem;
    assign w_fix_res = r_op[1] ? w_rem_s : (r_bzero ? 32'hFFFF_FFFF : w_quo_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = w_fast ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == 5'd31) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= 2'd0;
            r_a_neg   <= 1'b0;
            r_b_neg   <= 1'b0;
            r_bzero   <= 1'b0;
            r_rem     <= 32'd0;
            r_quo     <= 32'd0;
            r_bmag    <= 32'd0;
            r_cnt     <= 5'd0;
            r_result  <= 32'd0;
            r_divzero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_op    <= op;
                    r_a_neg <= w_a_neg;
                    r_b_neg <= w_b_neg;
                    r_bzero <= (b == 32'd0);
                    r_bmag  <= w_b_mag;
                    r_rem   <= 32'd0;
                    r_quo   <= w_a_mag;
                    r_cnt   <= 5'd0;
`ifdef DIV_FAST_SPECIAL_EN
                    if (w_fast) begin
                        r_result  <= w_fast_res;
                        r_divzero <= w_bz_in;
                    end
`endif
                end
                S_CALC: begin
                    if (!w_trial[32]) begin
                        r_rem <= w_trial[31:0];
                        r_quo <= {r_quo[30:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[31:0];
                        r_quo <= {r_quo[30:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 5'd1;
                end
                S_FIX: begin
                    r_result  <= w_fix_res;
                    r_divzero <= r_bzero;
                end
                default: ;
            endcase
        end
    end

    assign result  = r_result;
    assign divzero = r_divzero;
endmodule

// File: tb/tb_divider_32.sv
// Directed bench for divider_32: expected results queued at issue, checked when done fires.
module tb_divider_32;
    logic        clk, rst_n, start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, divzero;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   ntests = 0;
    int   nfail  = 0;

`ifdef DIV_FAST_SPECIAL_EN
    localparam int SPEC_LAT = 0;
`else
    localparam int SPEC_LAT = 33;
`endif
    localparam int FULL_LAT = 33;

    divider_32 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .divzero(divzero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive start for one cycle from a negedge; acceptance edge E0 is the next posedge
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic ed, input int el);
        exp_t e;
        e.res = er; e.dz = ed; e.lat = el;
        exp_q.push_back(e);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count edges after E0 until done; optionally pulse a stray start at cycle inj
    task automatic wait_check(input string tag, input int inj);
        int   lat;
        exp_t e;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == inj) begin
                op = 2'b01; a = 32'd1000; b = 32'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        e = exp_q.pop_front();
        chk({tag, "_lat"}, lat, e.lat);
        chk({tag, "_res"}, result, e.res);
        chk({tag, "_dz"}, {31'd0, divzero}, {31'd0, e.dz});
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        bit seen_done;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        @(negedge clk); @(negedge clk);
        chk("rst_busy",   {31'd0, busy},    32'd0);
        chk("rst_done",   {31'd0, done},    32'd0);
        chk("rst_result", result,           32'd0);
        chk("rst_dz",     {31'd0, divzero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'b01, 32'd100, 32'd7, 32'd14, 1'b0, FULL_LAT);                    wait_check("divu_100_7", 0);
        issue(2'b11, 32'd100, 32'd7, 32'd2, 1'b0, FULL_LAT);                     wait_check("remu_100_7", 0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, FULL_LAT);       wait_check("rem_m7_2", 0);
        issue(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, FULL_LAT);       wait_check("div_m7_2", 0);
        issue(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, SPEC_LAT);               wait_check("div_5_0", 0);
        issue(2'b11, 32'd5, 32'd0, 32'd5, 1'b1, SPEC_LAT);                       wait_check("remu_5_0", 0);
        issue(2'b00, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b1, SPEC_LAT);       wait_check("div_m7_0", 0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b1, SPEC_LAT);       wait_check("rem_m7_0", 0);
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, SPEC_LAT); wait_check("div_ovf", 0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, SPEC_LAT);       wait_check("rem_ovf", 0);
        issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, FULL_LAT);       wait_check("divu_big", 0);
        issue(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, FULL_LAT);       wait_check("div_7_m2", 0);

        // Stray start mid-operation is ignored; the next one after DONE is taken
        issue(2'b01, 32'd100, 32'd7, 32'd14, 1'b0, FULL_LAT);                    wait_check("ign_divu", 10);
        issue(2'b01, 32'd1000, 32'd1, 32'd1000, 1'b0, FULL_LAT);                 wait_check("after_ign", 0);

        // Reset mid-operation aborts with no done
        issue(2'b01, 32'd100, 32'd7, 32'd14, 1'b0, FULL_LAT);
        repeat (14) @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_front());
        chk("abort_busy",   {31'd0, busy},    32'd0);
        chk("abort_done",   {31'd0, done},    32'd0);
        chk("abort_result", result,           32'd0);
        chk("abort_dz",     {31'd0, divzero}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        chk("abort_no_done", {31'd0, seen_done}, 32'd0);
        issue(2'b01, 32'd9, 32'd3, 32'd3, 1'b0, FULL_LAT);                       wait_check("divu_9_3", 0);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
